// File: rtl/conv1d_psum_collector.sv
// conv1d_psum_collector
// Output-end consumer of the 1-D convolution PE chain. Sums every group of
// K_TAPS partial sums into one sample, saturates it to OUT_WIDTH and queues it
// in a show-ahead FIFO drained over a valid/ready port. The PE cannot be
// stalled, so results arriving while the FIFO is full are dropped and flagged.
// Optional build macro: COLLECTOR_BIAS_EN adds a per-group bias input that is
// folded into the first tap of each group.
`timescale 1ns/1ps
module conv1d_psum_collector #(
  parameter int PSUM_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int K_TAPS     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  pe_valid,
  input  logic [PSUM_WIDTH-1:0] pe_psum,
`ifdef COLLECTOR_BIAS_EN
  input  logic [PSUM_WIDTH-1:0] bias,
`endif
  output logic                  res_valid,
  output logic [OUT_WIDTH-1:0]  res_data,
  input  logic                  res_ready,
  output logic [7:0]            res_count,
  output logic [3:0]            tap_cnt,
  output logic                  sat_flag,
  output logic                  overflow_err,
  output logic                  fifo_full
);

`ifdef COLLECTOR_BIAS_EN
  // The bias is one extra operand on top of up to 16 taps, so one more
  // headroom bit keeps the accumulator from wrapping at K_TAPS=16.
  localparam int ACC_W = PSUM_WIDTH + 5;
`else
  localparam int ACC_W = PSUM_WIDTH + 4;
`endif
  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_TAP = 4'(K_TAPS - 1);

  // Registered state
  logic [ACC_W-1:0]     r_acc;
  logic [3:0]           r_tap_cnt;
  logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [7:0]           r_res_count;
  logic                 r_sat_flag;
  logic                 r_overflow_err;

  // Combinational helpers
  logic                 w_flush;
  logic                 w_tap;
  logic                 w_first_tap;
  logic                 w_last_tap;
  logic [ACC_W-1:0]     w_first;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_sat;
  logic [OUT_WIDTH-1:0] w_result;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_drop;

  // Reset and clear share one flush path; pe_valid is masked while flushing.
  assign w_flush     = !rst_n || clear;
  assign w_tap       = pe_valid && !w_flush;
  assign w_first_tap = (r_tap_cnt == 4'd0);
  assign w_last_tap  = (r_tap_cnt == LAST_TAP);

  // First tap of a group loads fresh (optionally biased); later taps add.
`ifdef COLLECTOR_BIAS_EN
  assign w_first = ACC_W'(pe_psum) + ACC_W'(bias);
`else
  assign w_first = ACC_W'(pe_psum);
`endif
  assign w_sum = w_first_tap ? w_first : (r_acc + ACC_W'(pe_psum));

  // Clamp the completed sum to the largest OUT_WIDTH value.
  generate
    if (OUT_WIDTH < ACC_W) begin : g_sat
      assign w_sat    = |w_sum[ACC_W-1:OUT_WIDTH];
      assign w_result = w_sat ? {OUT_WIDTH{1'b1}} : w_sum[OUT_WIDTH-1:0];
    end else begin : g_nosat
      assign w_sat    = 1'b0;
      assign w_result = OUT_WIDTH'(w_sum);
    end
  endgenerate

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees a slot on the same edge, so a full FIFO can still accept a
  // push when it is being read. An empty FIFO never pops, so a push into an
  // empty FIFO is always visible on the next cycle.
  assign w_pop      = !w_empty && res_ready && !w_flush;
  assign w_push_req = w_tap && w_last_tap;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Accumulator and tap index advance only on accepted taps; gaps hold them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register here sees pre-edge values.
    if (w_flush) begin
      r_acc     <= '0;
      r_tap_cnt <= 4'd0;
    end else if (w_tap) begin
      r_acc     <= w_sum;
      r_tap_cnt <= w_last_tap ? 4'd0 : (r_tap_cnt + 4'd1);
    end
  end

  // Result storage writes the clamped sum at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid.
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_result;
    end
  end

  // FIFO pointers move on accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Group counter and sticky error flags; dropped groups still count so the
  // downstream can detect how many samples were lost.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_res_count    <= 8'd0;
      r_sat_flag     <= 1'b0;
      r_overflow_err <= 1'b0;
    end else if (w_push_req) begin
      r_res_count <= r_res_count + 8'd1;
      if (w_sat)  r_sat_flag     <= 1'b1;
      if (w_drop) r_overflow_err <= 1'b1;
    end
  end

  // Show-ahead read port; data is forced to zero while empty.
  assign res_valid    = !w_empty;
  assign res_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign res_count    = r_res_count;
  assign tap_cnt      = r_tap_cnt;
  assign sat_flag     = r_sat_flag;
  assign overflow_err = r_overflow_err;
  assign fifo_full    = w_full;

endmodule

// File: tb/tb_conv1d_psum_collector.sv
// tb_conv1d_psum_collector
// Directed bench for conv1d_psum_collector with a queue-based reference model
// that is compared against the DUT every cycle, plus literal expectations.
// Build with COLLECTOR_BIAS_EN defined to exercise the bias input.
`timescale 1ns/1ps
module tb_conv1d_psum_collector;
  localparam int PW      = 16;
  localparam int OW      = 16;
  localparam int K       = 3;
  localparam int D       = 8;
  localparam longint OUT_MAX = (longint'(1) << OW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clear     = 1'b0;
  logic          pe_valid  = 1'b0;
  logic [PW-1:0] pe_psum   = '0;
  logic          res_ready = 1'b0;
`ifdef COLLECTOR_BIAS_EN
  logic [PW-1:0] bias      = '0;
`endif
  logic          res_valid;
  logic [OW-1:0] res_data;
  logic [7:0]    res_count;
  logic [3:0]    tap_cnt;
  logic          sat_flag;
  logic          overflow_err;
  logic          fifo_full;

  always #5 clk = ~clk;

  conv1d_psum_collector #(
    .PSUM_WIDTH(PW), .OUT_WIDTH(OW), .K_TAPS(K), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .pe_valid(pe_valid),
    .pe_psum(pe_psum),
`ifdef COLLECTOR_BIAS_EN
    .bias(bias),
`endif
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready),
    .res_count(res_count),
    .tap_cnt(tap_cnt),
    .sat_flag(sat_flag),
    .overflow_err(overflow_err),
    .fifo_full(fifo_full)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of queued results, running group sum and tap count.
  int     m_q[$];
  longint m_gsum = 0;
  int     m_gn   = 0;
  int     m_cnt  = 0;
  bit     m_sat  = 1'b0;
  bit     m_ovf  = 1'b0;

  always @(posedge clk) begin : model
    int     pre;
    bit     pop;
    bit     done;
    longint bterm;
    if (!rst_n || clear) begin
      m_q.delete();
      m_gsum = 0;
      m_gn   = 0;
      m_cnt  = 0;
      m_sat  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
`ifdef COLLECTOR_BIAS_EN
      bterm = longint'(bias);
`else
      bterm = 0;
`endif
      pre  = m_q.size();
      pop  = (pre > 0) && res_ready;
      done = 1'b0;
      if (pe_valid) begin
        if (m_gn == 0) m_gsum = longint'(pe_psum) + bterm;
        else           m_gsum = m_gsum + longint'(pe_psum);
        m_gn++;
        if (m_gn == K) begin
          done = 1'b1;
          m_gn = 0;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (done) begin
        if (m_gsum > OUT_MAX) m_sat = 1'b1;
        if (pre < D || pop) m_q.push_back(int'((m_gsum > OUT_MAX) ? OUT_MAX : m_gsum));
        else                m_ovf = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("res_valid",    res_valid,    m_q.size() > 0);
      check("res_data",     res_data,     (m_q.size() > 0) ? m_q[0] : 0);
      check("res_count",    res_count,    m_cnt);
      check("tap_cnt",      tap_cnt,      m_gn);
      check("sat_flag",     sat_flag,     m_sat);
      check("overflow_err", overflow_err, m_ovf);
      check("fifo_full",    fifo_full,    m_q.size() == D);
    end
  end

  // Apply one cycle of inputs; returns 1ns after the edge that consumed them.
  task automatic step(input bit v, input int p, input bit r, input bit c);
    pe_valid  = v;
    pe_psum   = PW'(p);
    res_ready = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic group(input int a, input int b, input int c);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int n;
    int last;

    // Reset
    rst_n = 1'b0;
    idle(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_valid",  res_valid,    0);
    check("rst_data",   res_data,     0);
    check("rst_count",  res_count,    0);
    check("rst_tap",    tap_cnt,      0);
    check("rst_sat",    sat_flag,     0);
    check("rst_ovf",    overflow_err, 0);
    check("rst_full",   fifo_full,    0);

    // Basic group with idle gaps between taps
    step(1'b1, 6, 1'b0, 1'b0);
    check("t1_tap1", tap_cnt, 1);
    idle(3);
    step(1'b1, 8, 1'b0, 1'b0);
    check("t1_tap2", tap_cnt, 2);
    idle(3);
    check("t1_hold_valid", res_valid, 0);
    step(1'b1, 6, 1'b0, 1'b0);
    check("t1_valid", res_valid, 1);
    check("t1_data",  res_data,  20);
    check("t1_count", res_count, 1);
    check("t1_tap0",  tap_cnt,   0);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t1_popped", res_valid, 0);

    // Saturation, then a normal group with sticky flag retained
    group(65535, 65535, 2);
    check("t2_sat_data", res_data, 65535);
    check("t2_sat_flag", sat_flag, 1);
    step(1'b0, 0, 1'b1, 1'b0);
    group(1, 1, 1);
    check("t2_data",   res_data,  3);
    check("t2_sticky", sat_flag,  1);
    check("t2_count",  res_count, 3);
    step(1'b0, 0, 1'b1, 1'b0);

    // Overflow: nine groups into an eight-entry FIFO
    step(1'b0, 0, 1'b0, 1'b1);
    check("t3_clr_sat", sat_flag, 0);
    for (int g = 0; g < 9; g++) group(1, 1, 1);
    check("t3_full",  fifo_full,    1);
    check("t3_ovf",   overflow_err, 1);
    check("t3_count", res_count,    9);
    n = 0;
    for (int i = 0; i < 20 && res_valid; i++) begin
      check("t3_drain_data", res_data, 3);
      n++;
      step(1'b0, 0, 1'b1, 1'b0);
    end
    check("t3_drain_n", n, 8);

    // Full FIFO with a pop on the last-tap edge: push succeeds, no error
    step(1'b0, 0, 1'b0, 1'b1);
    for (int g = 0; g < 8; g++) group(1, 1, 1);
    check("t4_full_before", fifo_full, 1);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);
    check("t4_ovf",  overflow_err, 0);
    check("t4_full", fifo_full,    1);
    n    = 0;
    last = -1;
    for (int i = 0; i < 20 && res_valid; i++) begin
      last = int'(res_data);
      n++;
      step(1'b0, 0, 1'b1, 1'b0);
    end
    check("t4_drain_n",    n,    8);
    check("t4_drain_last", last, 6);

    // Clear mid-group with pe_valid high; last tap lands with res_ready high
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b1);
    check("t5_clr_tap",   tap_cnt,   0);
    check("t5_clr_count", res_count, 0);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    check("t5_valid", res_valid,    1);
    check("t5_data",  res_data,     6);
    check("t5_count", res_count,    1);
    check("t5_ovf",   overflow_err, 0);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t5_empty", res_valid, 0);

`ifdef COLLECTOR_BIAS_EN
    // Bias folded into the first tap of the group
    bias = 16'd10;
    group(2, 3, 4);
    check("t6_bias_data", res_data, 19);
    step(1'b0, 0, 1'b1, 1'b0);
    bias = '0;
`endif

    // Reset mid-group with results queued and flags set
    group(65535, 65535, 65535);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    check("t7_pre_sat", sat_flag, 1);
    rst_n = 1'b0;
    step(1'b1, 9, 1'b1, 1'b0);
    check("t7_valid", res_valid,    0);
    check("t7_data",  res_data,     0);
    check("t7_count", res_count,    0);
    check("t7_tap",   tap_cnt,      0);
    check("t7_sat",   sat_flag,     0);
    check("t7_ovf",   overflow_err, 0);
    check("t7_full",  fifo_full,    0);
    rst_n = 1'b1;
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
